// File: rtl/keystream_packer_pkg.sv
// Shared definitions for the keystream packer: byte width, default buffer depth
// and the FSM state encoding.
package keystream_packer_pkg;

    localparam int BYTE_W             = 8;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_GATHER    = 2'd1;
    localparam logic [1:0] ST_WAIT_DATA = 2'd2;

    typedef logic [BYTE_W-1:0] byte_t;

    // The first bit shifted in ends up at the MSB once a byte is complete.
    function automatic byte_t ks_shift(input byte_t ks, input logic bit_in);
        return {ks[BYTE_W-2:0], bit_in};
    endfunction

endpackage

// File: rtl/keystream_packer_sync_fifo.sv
// Single-clock FIFO with registered storage; pointers carry one extra bit so
// that full and empty can be told apart when the address bits match.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i && !full_o) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i && !empty_o) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // NOTE: state flops use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the empty flag guards its contents.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/keystream_packer.sv
// Collects 8 keystream bits from an upstream LFSR, XORs them onto a plaintext
// byte and queues the ciphertext in an output FIFO.
module keystream_packer
    import keystream_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              k_i,
    output logic              lfsr_en_o,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    output logic [BYTE_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [1:0]       state_q, state_d;
    byte_t            ks_q, ks_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic fifo_full, fifo_empty, push;

    assign lfsr_en_o    = (state_q == ST_GATHER);
    assign data_ready_o = (state_q == ST_WAIT_DATA) && !fifo_full;
    assign busy_o       = (state_q != ST_IDLE);
    assign out_valid_o  = !fifo_empty;
    assign count_o      = count_q;
    // A stop on the handshake edge wins: the byte is dropped.
    assign push         = data_valid_i && data_ready_o && !stop;

    always_comb begin
        state_d   = state_q;
        ks_d      = ks_q;
        bit_cnt_d = bit_cnt_q;
        count_d   = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_GATHER;
            end
            ST_GATHER: begin
                ks_d      = ks_shift(ks_q, k_i);
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (push) begin
                    state_d   = ST_GATHER;
                    bit_cnt_d = '0;
                    count_d   = count_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (stop) begin
            state_d   = ST_IDLE;
            ks_d      = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ks_q      <= '0;
            bit_cnt_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            ks_q      <= ks_d;
            bit_cnt_q <= bit_cnt_d;
            count_q   <= count_d;
        end
    end

    sync_fifo #(
        .WIDTH(BYTE_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_data_i(data_i ^ ks_q),
        .pop_i      (out_valid_o && out_ready_i),
        .pop_data_o (out_data_o),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

endmodule

// File: tb/tb_keystream_packer.sv
// Bench for keystream_packer: directed scenarios plus random traffic, all
// checked every cycle against a queue-based behavioural model.
module tb_keystream_packer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0, stop = 1'b0, k_i = 1'b0;
    logic       lfsr_en_o;
    logic [7:0] data_i = 8'h00;
    logic       data_valid_i = 1'b0;
    logic       data_ready_o;
    logic [7:0] out_data_o;
    logic       out_valid_o;
    logic       out_ready_i = 1'b0;
    logic       busy_o;
    logic [15:0] count_o;

    int vectors = 0;
    int miscompares = 0;

    keystream_packer #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .k_i(k_i),
        .lfsr_en_o(lfsr_en_o), .data_i(data_i), .data_valid_i(data_valid_i),
        .data_ready_o(data_ready_o), .out_data_o(out_data_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .busy_o(busy_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode, number of bits gathered, keystream value, byte queue.
    typedef enum {M_IDLE, M_GATHER, M_WAIT} mode_e;
    mode_e      m_mode = M_IDLE;
    int         m_nbits = 0;
    logic [7:0] m_ks = 8'h00;
    logic [7:0] mq[$];
    logic [15:0] m_count = 16'h0;
    logic       m_ready, m_push, m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE; m_nbits = 0; m_ks = 8'h00; m_count = 16'h0;
            mq.delete();
        end else begin
            m_ready = (m_mode == M_WAIT) && (mq.size() < DEPTH);
            m_push  = m_ready && data_valid_i && !stop;
            m_pop   = (mq.size() != 0) && out_ready_i;
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back(data_i ^ m_ks);
                m_count = m_count + 16'd1;
            end
            if (stop) begin
                m_mode = M_IDLE; m_nbits = 0; m_ks = 8'h00;
            end else begin
                case (m_mode)
                    M_IDLE:   if (start) m_mode = M_GATHER;
                    M_GATHER: begin
                        m_ks = (m_ks * 2 + k_i) % 256;
                        m_nbits++;
                        if (m_nbits == 8) m_mode = M_WAIT;
                    end
                    M_WAIT:   if (m_push) begin m_mode = M_GATHER; m_nbits = 0; end
                    default:  m_mode = M_IDLE;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("lfsr_en", lfsr_en_o, m_mode == M_GATHER);
            check("data_ready", data_ready_o, (m_mode == M_WAIT) && (mq.size() < DEPTH));
            check("busy", busy_o, m_mode != M_IDLE);
            check("out_valid", out_valid_o, mq.size() != 0);
            check("out_data", out_data_o, (mq.size() != 0) ? mq[0] : 8'h00);
            check("count", count_o, m_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int lfsr_cycles);
        lfsr_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (data_ready_o) break;
            if (lfsr_en_o) lfsr_cycles++;
            tick();
        end
        if (!data_ready_o) check("wait_ready_timeout", 0, 1);
    endtask

    task automatic gather_byte(input logic [7:0] bits);
        for (int i = 7; i >= 0; i--) begin
            k_i = bits[i];
            tick();
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        int n;
        wait_ready(n);
        data_i = d;
        data_valid_i = 1'b1;
        tick();
        data_valid_i = 1'b0;
    endtask

    task automatic stop_and_drain();
        stop = 1'b1;
        out_ready_i = 1'b1;
        tick();
        stop = 1'b0;
        repeat (DEPTH + 2) tick();
        out_ready_i = 1'b0;
    endtask

    initial begin
        int n;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_data", out_data_o, 8'h00);
        check("rst_lfsr_en", lfsr_en_o, 0);
        check("rst_data_ready", data_ready_o, 0);
        check("rst_count", count_o, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // All-ones keystream XOR 0x0F.
        start = 1'b1; tick(); start = 1'b0;
        k_i = 1'b1;
        wait_ready(n);
        check("t1_lfsr_cycles", n, 8);
        data_i = 8'h0F; data_valid_i = 1'b1; tick(); data_valid_i = 1'b0;
        check("t1_out_valid", out_valid_o, 1);
        check("t1_out_data", out_data_o, 8'hF0);
        check("t1_count", count_o, 1);
        stop_and_drain();

        // Bit order: 1,0,1,1,0,0,1,0 gives keystream 0xB2.
        start = 1'b1; tick(); start = 1'b0;
        gather_byte(8'hB2);
        data_i = 8'hFF; data_valid_i = 1'b1; tick(); data_valid_i = 1'b0;
        check("t2_out_data", out_data_o, 8'h4D);
        stop_and_drain();

        // Fill the FIFO, then stall with a fifth byte waiting.
        start = 1'b1; tick(); start = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            gather_byte(8'($urandom));
            push_byte(8'($urandom));
        end
        gather_byte(8'($urandom));
        check("t3_full_ready", data_ready_o, 0);
        check("t3_full_lfsr", lfsr_en_o, 0);
        data_i = 8'h5A; data_valid_i = 1'b1;
        repeat (3) tick();
        check("t3_stall_ready", data_ready_o, 0);
        check("t3_stall_lfsr", lfsr_en_o, 0);
        check("t3_stall_count", count_o, 6);
        out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
        check("t3_after_pop_ready", data_ready_o, 1);
        tick();
        data_valid_i = 1'b0;
        check("t3_fifth_count", count_o, 7);
        stop_and_drain();
        check("t3_drained", out_valid_o, 0);

        // Abort mid-byte, then a restart needs a full 8 LFSR cycles.
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) begin k_i = 1'($urandom); tick(); end
        stop = 1'b1; tick(); stop = 1'b0;
        check("t4_idle", busy_o, 0);
        check("t4_no_push", count_o, 7);
        check("t4_no_out", out_valid_o, 0);
        start = 1'b1; tick(); start = 1'b0;
        k_i = 1'b0;
        wait_ready(n);
        check("t4_restart_cycles", n, 8);

        // Simultaneous push and pop with two bytes queued.
        push_byte(8'h11);
        gather_byte(8'h3C);
        push_byte(8'h81);
        gather_byte(8'hA5);
        data_i = 8'h0F; data_valid_i = 1'b1; out_ready_i = 1'b1;
        tick();
        data_valid_i = 1'b0;
        check("t5_head", out_data_o, 8'hBD);
        tick();
        check("t5_second", out_data_o, 8'hAA);
        tick();
        out_ready_i = 1'b0;
        check("t5_empty_after_two", out_valid_o, 0);
        check("t5_count", count_o, 10);
        stop = 1'b1; tick(); stop = 1'b0;

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            start        = ($urandom % 16) == 0;
            stop         = ($urandom % 64) == 0;
            k_i          = 1'($urandom);
            data_valid_i = ($urandom % 4) != 0;
            data_i       = 8'($urandom);
            out_ready_i  = ($urandom % 3) != 0;
            tick();
        end
        start = 1'b0; data_valid_i = 1'b0;
        stop_and_drain();
        check("t6_drained", out_valid_o, 0);

        // Asynchronous reset with three bytes buffered.
        start = 1'b1; tick(); start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            gather_byte(8'($urandom));
            push_byte(8'($urandom));
        end
        check("t7_pre_valid", out_valid_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_out_valid", out_valid_o, 0);
        check("t7_rst_count", count_o, 0);
        check("t7_rst_busy", busy_o, 0);
        check("t7_rst_lfsr", lfsr_en_o, 0);
        check("t7_rst_out_data", out_data_o, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
